bridge_buffer_mh: RTL and testbench
===================================

Name: bridge_buffer_mh

Overview:
- Multi-head, double-buffered bridge between the linear-projection outputs and the next attention matmul (Qn·KnT).
- Per head, it captures West (Q) and North (K) row-beats into ping-pong banks, then sequences every West×North tile pair into the multi-matmul wrapper.
- It generates the wrapper's reset, accumulator-reset and enable, and applies back-pressure to the producer.
- It generalises the single-instance buffer with a head count, configurable depths, ping-pong overlap, an in_ready handshake and overflow detection.

Parameters:
- NUM_HEADS, 4, number of heads in lockstep (one bank pair per head).
- TOTAL_INPUT_W, 2, lanes per input beat.
- W_IN_WIDTH, 256, bits per West lane.
- N_IN_WIDTH, 256, bits per North lane.
- DEPTH_W, 4, West beats per tile set.
- DEPTH_N, 4, North beats per tile set.
- RST_CYCLES, 2, cycles internal_rst_n_ctrl is held low per tile set.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid_w  in  1  West beat valid.
- in_valid_n  in  1  North beat valid.
- in_ready  out  1  fill bank can accept a beat.
- w_din  in  [NUM_HEADS][TOTAL_INPUT_W]×W_IN_WIDTH  West lanes.
- n_din  in  [NUM_HEADS][TOTAL_INPUT_W]×N_IN_WIDTH  North lanes.
- acc_done_wrap  in  1  wrapper accumulation complete.
- systolic_finish_wrap  in  1  wrapper drained.
- w_dout  out  [NUM_HEADS]×(TOTAL_INPUT_W·W_IN_WIDTH)  West operand, lane 0 at LSB.
- n_dout  out  [NUM_HEADS]×(TOTAL_INPUT_W·N_IN_WIDTH)  North operand, lane 0 at LSB.
- internal_rst_n_ctrl  out  1  wrapper reset, active low.
- internal_reset_acc_ctrl  out  1  accumulator clear pulse.
- enable_matmul  out  1  wrapper enable.
- out_valid  out  1  one-cycle pulse: wrapper output for current pair is valid.
- pair_idx  out  clog2(DEPTH_W·DEPTH_N)  current pair index, i·DEPTH_N+j.
- overflow  out  1  sticky: beat offered while in_ready=0.

Behaviour:
- Reset values:
  - in_ready=1, internal_rst_n_ctrl=0, enable_matmul=0, internal_reset_acc_ctrl=0.
  - out_valid=0, pair_idx=0, overflow=0.
  - w_dout/n_dout=0; all bank flags empty; FSM=IDLE.
  - Reset mid-operation discards all banks and counters.
- Write side:
  - Independent West and North write counters; each beat is stored at its counter in the fill bank, all heads in the same cycle.
  - A bank is full when the West count reaches DEPTH_W and the North count reaches DEPTH_N; the fill pointer then toggles.
  - A beat with in_valid_x=1 and in_ready=1 is accepted in that cycle.
- in_ready:
  - Low when the fill bank is full (both banks occupied).
  - Also low for a side whose count has already reached its depth while the other side is still filling.
- overflow: set when in_valid_w or in_valid_n is high while in_ready=0; the beat is dropped; cleared only by reset.
- FSM (read side operates on the drain bank):
  - IDLE: wait for a full bank → RST.
  - RST: internal_rst_n_ctrl=0 for RST_CYCLES, then → CLR.
  - CLR: internal_reset_acc_ctrl=1 for one cycle; w_dout/n_dout registered from drain[i], drain[j] → RUN.
  - RUN: enable_matmul=1 until acc_done_wrap=1; out_valid pulses that cycle → DRAIN.
  - DRAIN: enable_matmul stays 1 until systolic_finish_wrap → NEXT.
  - NEXT: j++; on wrap j=0 and i++.
    - If pairs remain → CLR.
    - Otherwise mark the bank empty; → RST if the other bank is full, else IDLE.
- acc_done_wrap and systolic_finish_wrap in the same cycle: out_valid pulses and the FSM goes directly to NEXT.
- Strobes outside RUN/DRAIN are ignored.
- Simultaneous write completion of one bank and drain completion of the other: the bank is freed and in_ready rises the next cycle; there is no bubble on the write side.
- Operand latency: w_dout/n_dout are stable from the CLR edge +1 through the end of DRAIN.

Decomposition:
- Shared package (buffer pkg):
  - Lane/module widths, DEPTH_W/DEPTH_N, NUM_HEADS defaults.
  - State typedef enum {IDLE,RST,CLR,RUN,DRAIN,NEXT}.
  - Packed types for West and North module words.
- Sub-module bridge_pingpong_bank:
  - One per head per side.
  - Two register arrays plus write address and read address.
  - Instantiated NUM_HEADS×2 under one shared controller.

Test Plan:
- Single set, NUM_HEADS=4, DEPTH 4/4: write 4+4 beats carrying pattern head·16+beat; model wrapper with acc_done 3 cycles after enable.
  - Expect 16 out_valid pulses, pair_idx 0..15, w_dout=beat i and n_dout=beat j per head.
- Back-to-back sets: stream 3 full sets continuously.
  - Set 2 fills during set 1 drain.
  - in_ready drops only when both banks are full.
  - No data corruption; 48 pulses total.
- Overflow: hold in_valid_w=1 with both banks full.
  - overflow=1 next cycle, stays 1.
  - Dropped beat never appears on w_dout.
- Same-cycle acc_done_wrap and systolic_finish_wrap on every pair.
  - One out_valid per pair; CLR follows NEXT directly.
- Mid-drain reset: assert rst_n=0 at pair 5.
  - All outputs return to reset values asynchronously.
  - in_ready=1; pair_idx=0 after release.
- Unbalanced sides: send 4 North beats before any West.
  - North in_ready low after beat 4; West still accepted.
  - RST entered once the 4th West beat lands.

Source files
------------

// File: rtl/bridge_buffer_mh_pkg.sv
// Shared sizes, state encoding and bus word types for the multi-head
// ping-pong bridge between the projection outputs and the Qn*KnT matmul.
package bridge_buffer_mh_pkg;

  localparam int NUM_HEADS     = 4;
  localparam int TOTAL_INPUT_W = 2;
  localparam int W_IN_WIDTH    = 256;
  localparam int N_IN_WIDTH    = 256;
  localparam int DEPTH_W       = 4;
  localparam int DEPTH_N       = 4;
  localparam int RST_CYCLES    = 2;

  localparam int W_WORD_W  = TOTAL_INPUT_W * W_IN_WIDTH;
  localparam int N_WORD_W  = TOTAL_INPUT_W * N_IN_WIDTH;
  localparam int NUM_PAIRS = DEPTH_W * DEPTH_N;
  localparam int PAIR_W    = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int WA_W      = (DEPTH_W > 1) ? $clog2(DEPTH_W) : 1;
  localparam int NA_W      = (DEPTH_N > 1) ? $clog2(DEPTH_N) : 1;
  localparam int WC_W      = $clog2(DEPTH_W + 1);
  localparam int NC_W      = $clog2(DEPTH_N + 1);
  localparam int RC_W      = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RST   = 3'd1,
    CLR   = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    NEXT  = 3'd5
  } state_t;

  // Lane 0 sits at the LSB of each module word.
  typedef logic [W_WORD_W-1:0] w_word_t;
  typedef logic [N_WORD_W-1:0] n_word_t;
  typedef w_word_t [NUM_HEADS-1:0] w_bus_t;
  typedef n_word_t [NUM_HEADS-1:0] n_bus_t;

endpackage

// File: rtl/bridge_buffer_mh_if.sv
// Producer / wrapper facing bus of the bridge. The bridge uses the slave
// modport; whoever feeds beats and models the wrapper uses master.
interface bridge_buffer_mh_if;
  import bridge_buffer_mh_pkg::*;

  // Handshake: a beat on side x transfers in a cycle where in_valid_x and
  // in_ready are both 1 at the rising edge. in_ready may fall combinationally
  // when a valid is raised on a side that already holds its full depth;
  // offering a beat while in_ready is 0 drops it and sets the sticky overflow.
  logic                  in_valid_w;
  logic                  in_valid_n;
  logic                  in_ready;
  w_bus_t                w_din;
  n_bus_t                n_din;
  logic                  acc_done_wrap;
  logic                  systolic_finish_wrap;
  w_bus_t                w_dout;
  n_bus_t                n_dout;
  logic                  internal_rst_n_ctrl;
  logic                  internal_reset_acc_ctrl;
  logic                  enable_matmul;
  logic                  out_valid;
  logic [PAIR_W-1:0]     pair_idx;
  logic                  overflow;
  state_t                state_dbg;

  modport slave (
    input  in_valid_w, in_valid_n, w_din, n_din, acc_done_wrap, systolic_finish_wrap,
    output in_ready, w_dout, n_dout, internal_rst_n_ctrl, internal_reset_acc_ctrl,
           enable_matmul, out_valid, pair_idx, overflow, state_dbg
  );

  modport master (
    output in_valid_w, in_valid_n, w_din, n_din, acc_done_wrap, systolic_finish_wrap,
    input  in_ready, w_dout, n_dout, internal_rst_n_ctrl, internal_reset_acc_ctrl,
           enable_matmul, out_valid, pair_idx, overflow, state_dbg
  );

endinterface

// File: rtl/bridge_buffer_mh_pingpong_bank.sv
// One head, one side: two storage banks selected by the fill/drain pointers
// and a registered operand that is loaded only when the controller asks.
module bridge_buffer_mh_pingpong_bank #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             wsel,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rsel,
  input  logic [AW-1:0]    raddr,
  input  logic             ld,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [WIDTH-1:0] dout_q, dout_d;

  // Storage needs no reset: bank occupancy flags in the controller gate all use.
  always_ff @(posedge clk) begin
    if (we) mem_q[wsel][waddr] <= wdata;
  end

  always_comb begin
    dout_d = dout_q;
    if (ld) dout_d = mem_q[rsel][raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_q <= '0;
    else        dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

// File: rtl/bridge_buffer_mh.sv
// Multi-head ping-pong bridge: fills one bank pair per head while the other is
// sequenced as every West x North tile pair into the multi-matmul wrapper.
module bridge_buffer_mh
  import bridge_buffer_mh_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  bridge_buffer_mh_if.slave bus
);

  state_t            state_q, state_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic [1:0]        full_q, full_d;
  logic              fill_ptr_q, fill_ptr_d;
  logic              drain_ptr_q, drain_ptr_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d, wcnt_nx;
  logic [NC_W-1:0]   ncnt_q, ncnt_d, ncnt_nx;
  logic [WA_W-1:0]   i_q, i_d;
  logic [NA_W-1:0]   j_q, j_d;
  logic [PAIR_W-1:0] pair_q, pair_d;
  logic              rst_ctrl_q, rst_ctrl_d;
  logic              acc_clr_q, acc_clr_d;
  logic              en_q, en_d;
  logic              out_valid_q, out_valid_d;
  logic              overflow_q, overflow_d;

  logic in_ready, acc_w, acc_n, set_done, ld;

  // A side that already holds its depth stalls only the beats offered on it.
  assign in_ready = ~full_q[fill_ptr_q]
                  & ~(bus.in_valid_w & (wcnt_q == WC_W'(DEPTH_W)))
                  & ~(bus.in_valid_n & (ncnt_q == NC_W'(DEPTH_N)));
  assign acc_w    = bus.in_valid_w & in_ready;
  assign acc_n    = bus.in_valid_n & in_ready;
  assign wcnt_nx  = wcnt_q + WC_W'(acc_w);
  assign ncnt_nx  = ncnt_q + NC_W'(acc_n);
  assign set_done = (wcnt_nx == WC_W'(DEPTH_W)) && (ncnt_nx == NC_W'(DEPTH_N));

  always_comb begin
    state_d     = state_q;
    rcnt_d      = rcnt_q;
    full_d      = full_q;
    fill_ptr_d  = fill_ptr_q;
    drain_ptr_d = drain_ptr_q;
    wcnt_d      = wcnt_nx;
    ncnt_d      = ncnt_nx;
    i_d         = i_q;
    j_d         = j_q;
    pair_d      = pair_q;
    out_valid_d = 1'b0;
    ld          = 1'b0;
    overflow_d  = overflow_q | ((bus.in_valid_w | bus.in_valid_n) & ~in_ready);

    if (set_done) begin
      full_d[fill_ptr_q] = 1'b1;
      fill_ptr_d         = ~fill_ptr_q;
      wcnt_d             = '0;
      ncnt_d             = '0;
    end

    case (state_q)
      IDLE: if (full_q[drain_ptr_q]) begin
        state_d = RST;
        rcnt_d  = '0;
      end
      RST: begin
        if (rcnt_q == RC_W'(RST_CYCLES - 1)) state_d = CLR;
        else                                 rcnt_d  = rcnt_q + RC_W'(1);
      end
      CLR: begin
        ld      = 1'b1;
        state_d = RUN;
      end
      RUN: if (bus.acc_done_wrap) begin
        out_valid_d = 1'b1;
        state_d     = bus.systolic_finish_wrap ? NEXT : DRAIN;
      end
      DRAIN: if (bus.systolic_finish_wrap) state_d = NEXT;
      NEXT: begin
        if (pair_q == PAIR_W'(NUM_PAIRS - 1)) begin
          // full_d already reflects a fill completing in this same cycle.
          full_d[drain_ptr_q] = 1'b0;
          drain_ptr_d         = ~drain_ptr_q;
          i_d                 = '0;
          j_d                 = '0;
          pair_d              = '0;
          rcnt_d              = '0;
          state_d             = full_d[~drain_ptr_q] ? RST : IDLE;
        end else begin
          pair_d  = pair_q + PAIR_W'(1);
          state_d = CLR;
          if (j_q == NA_W'(DEPTH_N - 1)) begin
            j_d = '0;
            i_d = i_q + WA_W'(1);
          end else begin
            j_d = j_q + NA_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rst_ctrl_d = !(state_d inside {IDLE, RST});
    acc_clr_d  = (state_d == CLR);
    en_d       = (state_d inside {RUN, DRAIN});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rcnt_q      <= '0;
      full_q      <= '0;
      fill_ptr_q  <= 1'b0;
      drain_ptr_q <= 1'b0;
      wcnt_q      <= '0;
      ncnt_q      <= '0;
      i_q         <= '0;
      j_q         <= '0;
      pair_q      <= '0;
      rst_ctrl_q  <= 1'b0;
      acc_clr_q   <= 1'b0;
      en_q        <= 1'b0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      full_q      <= full_d;
      fill_ptr_q  <= fill_ptr_d;
      drain_ptr_q <= drain_ptr_d;
      wcnt_q      <= wcnt_d;
      ncnt_q      <= ncnt_d;
      i_q         <= i_d;
      j_q         <= j_d;
      pair_q      <= pair_d;
      rst_ctrl_q  <= rst_ctrl_d;
      acc_clr_q   <= acc_clr_d;
      en_q        <= en_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  for (genvar h = 0; h < NUM_HEADS; h++) begin : g_head
    bridge_buffer_mh_pingpong_bank #(.WIDTH(W_WORD_W), .DEPTH(DEPTH_W), .AW(WA_W)) u_w_bank (
      .clk(clk), .rst_n(rst_n), .we(acc_w), .wsel(fill_ptr_q),
      .waddr(wcnt_q[WA_W-1:0]), .wdata(bus.w_din[h]), .rsel(drain_ptr_q),
      .raddr(i_q), .ld(ld), .dout(bus.w_dout[h])
    );
    bridge_buffer_mh_pingpong_bank #(.WIDTH(N_WORD_W), .DEPTH(DEPTH_N), .AW(NA_W)) u_n_bank (
      .clk(clk), .rst_n(rst_n), .we(acc_n), .wsel(fill_ptr_q),
      .waddr(ncnt_q[NA_W-1:0]), .wdata(bus.n_din[h]), .rsel(drain_ptr_q),
      .raddr(j_q), .ld(ld), .dout(bus.n_dout[h])
    );
  end

  assign bus.in_ready                = in_ready;
  assign bus.internal_rst_n_ctrl     = rst_ctrl_q;
  assign bus.internal_reset_acc_ctrl = acc_clr_q;
  assign bus.enable_matmul           = en_q;
  assign bus.out_valid               = out_valid_q;
  assign bus.pair_idx                = pair_q;
  assign bus.overflow                = overflow_q;
  assign bus.state_dbg               = state_q;

endmodule

// File: tb/tb_bridge_buffer_mh.sv
// Directed-sequence bench with random payloads: a tile-pair scoreboard built
// from each written set (cartesian product of West and North beats).
module tb_bridge_buffer_mh;
  import bridge_buffer_mh_pkg::*;

  localparam int WB      = NUM_HEADS * W_WORD_W;
  localparam int NB      = NUM_HEADS * N_WORD_W;
  localparam int WIDE    = (WB > NB) ? WB : NB;
  localparam int EXP_W   = PAIR_W + WB + NB;
  localparam int TIMEOUT = 2000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bridge_buffer_mh_if bus();
  bridge_buffer_mh dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e;
  bit same_mode = 0, hold = 0, spur = 0, prev_ov = 0, acc_sent = 0;
  int ecnt = 0;
  w_bus_t cur_w [DEPTH_W];
  n_bus_t cur_n [DEPTH_N];

  // ---------------- checkers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_wide(input string tag, input logic [WIDE-1:0] got, input logic [WIDE-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed [63:0]=%0h expected [63:0]=%0h", tag, got[63:0], exp[63:0]);
    end
  endtask

  // ---------------- wrapper model ----------------
  always @(negedge clk) begin
    bus.acc_done_wrap        = 1'b0;
    bus.systolic_finish_wrap = 1'b0;
    if (!rst_n || !bus.enable_matmul) begin
      ecnt = 0;
      acc_sent = 0;
      if (spur && rst_n) begin
        bus.acc_done_wrap        = 1'b1;
        bus.systolic_finish_wrap = 1'b1;
      end
    end else begin
      ecnt++;
      if (!acc_sent) begin
        if (!hold && ecnt >= 3) begin
          bus.acc_done_wrap = 1'b1;
          acc_sent = 1;
          ecnt = 0;
          if (same_mode) bus.systolic_finish_wrap = 1'b1;
        end
      end else if (ecnt == 2) begin
        bus.systolic_finish_wrap = 1'b1;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        pulses++;
        check("out_valid_single_cycle", prev_ov, 0);
        if (exp_q.size() == 0) begin
          check("out_valid_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pair_idx", bus.pair_idx, mon_e[NB+WB +: PAIR_W]);
          check_wide("w_dout", bus.w_dout, mon_e[NB +: WB]);
          check_wide("n_dout", bus.n_dout, mon_e[0 +: NB]);
        end
      end
      prev_ov = bus.out_valid;
    end else begin
      prev_ov = 0;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic w_bus_t rand_w();
    logic [WB-1:0] t;
    for (int k = 0; k < WB / 32; k++) t[k*32 +: 32] = $urandom;
    return t;
  endfunction

  function automatic n_bus_t rand_n();
    logic [NB-1:0] t;
    for (int k = 0; k < NB / 32; k++) t[k*32 +: 32] = $urandom;
    return t;
  endfunction

  task automatic gen_set();
    for (int i = 0; i < DEPTH_W; i++) cur_w[i] = rand_w();
    for (int j = 0; j < DEPTH_N; j++) cur_n[j] = rand_n();
  endtask

  task automatic push_set();
    for (int i = 0; i < DEPTH_W; i++)
      for (int j = 0; j < DEPTH_N; j++)
        exp_q.push_back({PAIR_W'(i * DEPTH_N + j), cur_w[i], cur_n[j]});
  endtask

  task automatic send_beat(input bit do_w, input bit do_n, input w_bus_t wd, input n_bus_t nd);
    int t = 0;
    bit done = 0;
    while (!done && t < TIMEOUT) begin
      @(negedge clk);
      bus.w_din = wd;
      bus.n_din = nd;
      bus.in_valid_w = do_w;
      bus.in_valid_n = do_n;
      #1;
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end else begin
        t++;
      end
      bus.in_valid_w = 1'b0;
      bus.in_valid_n = 1'b0;
    end
    check("beat_accepted", done, 1);
  endtask

  task automatic send_set();
    for (int k = 0; k < DEPTH_W; k++) send_beat(1, 1, cur_w[k], cur_n[k]);
  endtask

  task automatic wait_empty(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    check(tag, exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p0;
    int t;
    bit seen;
    bus.in_valid_w = 1'b0;
    bus.in_valid_n = 1'b0;
    bus.w_din = '0;
    bus.n_din = '0;

    // Reset values
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_internal_rst_n", bus.internal_rst_n_ctrl, 0);
    check("rst_reset_acc", bus.internal_reset_acc_ctrl, 0);
    check("rst_enable", bus.enable_matmul, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_pair_idx", bus.pair_idx, 0);
    check("rst_overflow", bus.overflow, 0);
    check_wide("rst_w_dout", bus.w_dout, '0);
    check_wide("rst_n_dout", bus.n_dout, '0);
    check("rst_state", bus.state_dbg, IDLE);

    // Single set
    gen_set(); send_set(); push_set();
    wait_empty("t1_drain");
    check("t1_pulses", pulses, 16);
    check("t1_idle", bus.state_dbg, IDLE);

    // Three back-to-back sets
    p0 = pulses;
    for (int s = 0; s < 3; s++) begin
      gen_set(); send_set(); push_set();
    end
    check("t2_overlap", (pulses - p0) < 48, 1);
    wait_empty("t2_drain");
    check("t2_pulses", pulses - p0, 48);
    check("t2_no_overflow", bus.overflow, 0);

    // Both banks full, then an illegal beat
    hold = 1;
    p0 = pulses;
    gen_set(); send_set(); push_set();
    repeat (6) @(negedge clk);
    check("t3_ready_one_bank_full", bus.in_ready, 1);
    check("t3_enable_while_held", bus.enable_matmul, 1);
    gen_set(); send_set(); push_set();
    @(negedge clk);
    check("t3_ready_both_full", bus.in_ready, 0);
    check("t3_overflow_before", bus.overflow, 0);
    bus.w_din = rand_w();
    bus.in_valid_w = 1'b1;
    @(negedge clk);
    bus.in_valid_w = 1'b0;
    check("t3_overflow_set", bus.overflow, 1);
    repeat (5) @(negedge clk);
    check("t3_overflow_sticky", bus.overflow, 1);
    hold = 0;
    gen_set(); send_set(); push_set();
    wait_empty("t3_drain");
    check("t3_pulses", pulses - p0, 48);
    check("t3_overflow_still", bus.overflow, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t3_overflow_cleared", bus.overflow, 0);
    check("t3_ready_after_reset", bus.in_ready, 1);

    // Same-cycle acc_done and finish
    same_mode = 1;
    p0 = pulses;
    gen_set(); send_set(); push_set();
    wait_empty("t4_drain");
    check("t4_pulses", pulses - p0, 16);
    same_mode = 0;

    // Reset in the middle of a drain
    gen_set(); send_set(); push_set();
    t = 0; seen = 0;
    while (!seen && t < TIMEOUT) begin
      @(negedge clk);
      if (bus.pair_idx == PAIR_W'(5)) seen = 1;
      t++;
    end
    check("t5_reached_pair5", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_in_ready", bus.in_ready, 1);
    check("t5_async_rst_ctrl", bus.internal_rst_n_ctrl, 0);
    check("t5_async_enable", bus.enable_matmul, 0);
    check("t5_async_reset_acc", bus.internal_reset_acc_ctrl, 0);
    check("t5_async_out_valid", bus.out_valid, 0);
    check("t5_async_pair_idx", bus.pair_idx, 0);
    check_wide("t5_async_w_dout", bus.w_dout, '0);
    check_wide("t5_async_n_dout", bus.n_dout, '0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_pair_after_release", bus.pair_idx, 0);
    check("t5_state_after_release", bus.state_dbg, IDLE);
    p0 = pulses;
    gen_set(); send_set(); push_set();
    wait_empty("t5_post_reset_drain");
    check("t5_pulses", pulses - p0, 16);

    // North side completes first
    gen_set();
    for (int k = 0; k < DEPTH_N; k++) send_beat(0, 1, '0, cur_n[k]);
    @(negedge clk);
    bus.in_valid_n = 1'b1;
    #1;
    check("t6_north_ready_low", bus.in_ready, 0);
    bus.in_valid_n = 1'b0;
    for (int k = 0; k < DEPTH_W - 1; k++) send_beat(1, 0, cur_w[k], '0);
    @(negedge clk);
    check("t6_idle_before_last_w", bus.state_dbg, IDLE);
    send_beat(1, 0, cur_w[DEPTH_W-1], '0);
    push_set();
    t = 0; seen = 0;
    while (!seen && t < 5) begin
      @(negedge clk);
      if (bus.state_dbg == RST) seen = 1;
      t++;
    end
    check("t6_rst_entered", seen, 1);
    check("t6_no_overflow", bus.overflow, 0);
    wait_empty("t6_drain");

    // Strobes while idle must be ignored
    p0 = pulses;
    spur = 1;
    repeat (5) @(negedge clk);
    spur = 0;
    repeat (3) @(negedge clk);
    check("t7_no_spurious_pulse", pulses - p0, 0);
    check("t7_still_idle", bus.state_dbg, IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
